// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding, address width and reset vector.
package cpu_pkg;
   localparam int          ADDR_W           = 32;
   localparam int          INST_W           = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [0:0] {
      S_REQ = 1'b0,
      S_OUT = 1'b1
   } fetch_state_t;
endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: jump beats branch, branch beats the sequential npc.
module pc_next_sel
   import cpu_pkg::*;
#(
   parameter int AW = ADDR_W
) (
   input  logic          jump_en,
   input  logic [AW-1:0] jump_target,
   input  logic          branch_en,
   input  logic [AW-1:0] branch_target,
   input  logic [AW-1:0] npc_in,
   output logic [AW-1:0] next_pc,
   output logic          redirect
);
   always_comb begin
      next_pc  = npc_in;
      redirect = jump_en | branch_en;
      if (jump_en)
         next_pc = jump_target;
      else if (branch_en)
         next_pc = branch_target;
   end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch handshake between npc, instruction memory and decode.
//   state | meaning
//   S_REQ | fetch request outstanding (or about to be issued after reset)
//   S_OUT | fetched instruction held for decode until inst_ready
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          AW       = ADDR_W,
   parameter int          DW       = INST_W
) (
   input  logic          clk,
   input  logic          rst,
   output logic [AW-1:0] pc,
   input  logic [AW-1:0] npc_in,
   input  logic          jump_en,
   input  logic [AW-1:0] jump_target,
   input  logic          branch_en,
   input  logic [AW-1:0] branch_target,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [DW-1:0] imem_rdata,
   output logic          inst_valid,
   input  logic          inst_ready,
   output logic [DW-1:0] inst,
   output logic [AW-1:0] inst_pc
);
   fetch_state_t  state;
   logic          kill;
   logic [AW-1:0] next_pc;
   logic          redirect;
   logic [AW-1:0] accept_pc;

   pc_next_sel #(.AW(AW)) u_sel (
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .npc_in        (npc_in),
      .next_pc       (next_pc),
      .redirect      (redirect)
   );

   // In S_OUT, kill marks that pc already holds a redirect target, so npc_in must not be used.
   assign accept_pc = (redirect || !kill) ? next_pc : pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= AW'(RESET_PC);
         kill       <= 1'b0;
         imem_req   <= 1'b0;
         imem_addr  <= AW'(RESET_PC);
         inst_valid <= 1'b0;
         inst       <= '0;
         inst_pc    <= '0;
      end else begin
         unique case (state)
            S_REQ: begin
               if (!imem_req) begin
                  imem_req  <= 1'b1;
                  imem_addr <= redirect ? next_pc : pc;
                  if (redirect) pc <= next_pc;
               end else if (imem_ack) begin
                  if (kill || redirect) begin
                     kill      <= 1'b0;
                     imem_addr <= redirect ? next_pc : pc;
                     if (redirect) pc <= next_pc;
                  end else begin
                     inst       <= imem_rdata;
                     inst_pc    <= imem_addr;
                     inst_valid <= 1'b1;
                     imem_req   <= 1'b0;
                     state      <= S_OUT;
                  end
               end else if (redirect) begin
                  pc   <= next_pc;
                  kill <= 1'b1;
               end
            end
            S_OUT: begin
               if (inst_ready) begin
                  pc         <= accept_pc;
                  imem_addr  <= accept_pc;
                  imem_req   <= 1'b1;
                  inst_valid <= 1'b0;
                  kill       <= 1'b0;
                  state      <= S_REQ;
               end else if (redirect) begin
                  pc   <= next_pc;
                  kill <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector table plus a zero-wait streaming sequence and handshake invariant monitors.
module tb_pc_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc, npc_in;
   logic        jump_en = 1'b0, branch_en = 1'b0;
   logic [31:0] jump_target = '0, branch_target = '0;
   logic        imem_req, imem_ack = 1'b0;
   logic [31:0] imem_addr, imem_rdata, rdata_drv = '0;
   logic        inst_valid, inst_ready = 1'b0;
   logic [31:0] inst, inst_pc;
   logic        use_mem = 1'b0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign npc_in     = pc + 32'd1;
   assign imem_rdata = use_mem ? {16'hA5A5, imem_addr[15:0]} : rdata_drv;

   pc_fetch_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .pc            (pc),
      .npc_in        (npc_in),
      .jump_en       (jump_en),
      .jump_target   (jump_target),
      .branch_en     (branch_en),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst          (inst),
      .inst_pc       (inst_pc)
   );

   typedef struct {
      logic        rst, ack;
      logic [31:0] rdata;
      logic        ready, jen;
      logic [31:0] jt;
      logic        ben;
      logic [31:0] bt;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] inst, ipc, pc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic r, logic a, logic [31:0] d, logic rdy, logic je, logic [31:0] jt,
                               logic be, logic [31:0] bt, logic req, logic [31:0] addr, logic vld,
                               logic [31:0] ins, logic [31:0] ipc, logic [31:0] p);
      vec_t v;
      v.rst = r; v.ack = a; v.rdata = d; v.ready = rdy; v.jen = je; v.jt = jt; v.ben = be; v.bt = bt;
      v.req = req; v.addr = addr; v.valid = vld; v.inst = ins; v.ipc = ipc; v.pc = p;
      vecs.push_back(v);
   endfunction

   // Handshake invariants, sampled mid-cycle
   logic        mon_on = 1'b0;
   logic        p_req, p_ack, p_valid, p_ready, p_rst;
   logic [31:0] p_addr;
   always @(negedge clk) begin
      if (mon_on) begin
         if (p_req && !p_ack && !p_rst) begin
            checks++;
            if (imem_addr !== p_addr) begin
               errors++;
               $display("FAIL addr_stable: imem_addr=%h was %h while request pending", imem_addr, p_addr);
            end
         end
         if (p_valid && !p_ready && !p_rst) begin
            checks++;
            if (inst_valid !== 1'b1) begin
               errors++;
               $display("FAIL valid_hold: inst_valid=%b dropped without inst_ready", inst_valid);
            end
         end
      end
      p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      p_valid = inst_valid; p_ready = inst_ready; p_rst = rst;
      mon_on = 1'b1;
   end

   localparam logic [31:0] STL = 32'h2002_0005;
   localparam logic [31:0] FF  = 32'hFFFF_FFFF;

   initial begin
      int n;
      //   rst ack rdata          rdy jen jt   ben bt     req addr  vld inst         ipc   pc
      add(1, 0, 0,              0, 0, 0,    0, 0,      0, 0,     0, 0,           0,    0);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 0,     0, 0,           0,    0);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 0,     0, 0,           0,    0);
      add(0, 1, 32'hA000_0000,  0, 0, 0,    0, 0,      0, 0,     1, 32'hA000_0000, 0,  0);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 1,     0, 32'hA000_0000, 0,  1);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 1,     0, 32'hA000_0000, 0,  1);
      add(0, 1, 32'hA000_0001,  0, 0, 0,    0, 0,      0, 1,     1, 32'hA000_0001, 1,  1);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 2,     0, 32'hA000_0001, 1,  2);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 2,     0, 32'hA000_0001, 1,  2);
      add(0, 1, STL,            0, 0, 0,    0, 0,      0, 2,     1, STL,         2,    2);
      for (int i = 0; i < 5; i++)
         add(0, 0, 0,           0, 0, 0,    0, 0,      0, 2,     1, STL,         2,    2);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 3,     0, STL,         2,    3);
      add(0, 1, 32'hA000_0003,  0, 0, 0,    0, 0,      0, 3,     1, 32'hA000_0003, 3,  3);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 4,     0, 32'hA000_0003, 3,  4);
      add(0, 0, 0,              0, 0, 0,    1, 32'h40, 1, 4,     0, 32'hA000_0003, 3,  32'h40);
      add(0, 0, 0,              0, 0, 0,    1, 32'h40, 1, 4,     0, 32'hA000_0003, 3,  32'h40);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 4,     0, 32'hA000_0003, 3,  32'h40);
      add(0, 1, 32'hDEAD_DEAD,  0, 0, 0,    0, 0,      1, 32'h40, 0, 32'hA000_0003, 3, 32'h40);
      add(0, 1, 32'hB000_0000,  0, 0, 0,    0, 0,      0, 32'h40, 1, 32'hB000_0000, 32'h40, 32'h40);
      add(0, 0, 0,              1, 1, 32'h100, 1, 32'h80, 1, 32'h100, 0, 32'hB000_0000, 32'h40, 32'h100);
      add(0, 1, 32'hC000_0000,  0, 0, 0,    0, 0,      0, 32'h100, 1, 32'hC000_0000, 32'h100, 32'h100);
      add(0, 0, 0,              0, 1, FF,   0, 0,      0, 32'h100, 1, 32'hC000_0000, 32'h100, FF);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, FF,    0, 32'hC000_0000, 32'h100, FF);
      add(0, 1, 32'hD000_0000,  0, 0, 0,    0, 0,      0, FF,    1, 32'hD000_0000, FF,  FF);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 0,     0, 32'hD000_0000, FF,  0);
      add(1, 1, 32'hEEEE_EEEE,  0, 0, 0,    0, 0,      0, 0,     0, 0,           0,    0);
      add(0, 0, 0,              0, 0, 0,    0, 0,      1, 0,     0, 0,           0,    0);
      add(0, 1, 32'hF000_0000,  0, 0, 0,    0, 0,      0, 0,     1, 32'hF000_0000, 0,  0);
      add(0, 0, 0,              1, 0, 0,    0, 0,      1, 1,     0, 32'hF000_0000, 0,  1);
      add(0, 1, 32'hBAD0_BAD0,  0, 0, 0,    1, 32'h20, 1, 32'h20, 0, 32'hF000_0000, 0, 32'h20);
      add(0, 1, 32'hF000_0001,  0, 0, 0,    0, 0,      0, 32'h20, 1, 32'hF000_0001, 32'h20, 32'h20);

      @(posedge clk); #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; imem_ack = vecs[i].ack; rdata_drv = vecs[i].rdata; inst_ready = vecs[i].ready;
         jump_en = vecs[i].jen; jump_target = vecs[i].jt; branch_en = vecs[i].ben; branch_target = vecs[i].bt;
         @(posedge clk); #1;
         checks++;
         if (imem_req !== vecs[i].req || imem_addr !== vecs[i].addr || inst_valid !== vecs[i].valid ||
             inst !== vecs[i].inst || inst_pc !== vecs[i].ipc || pc !== vecs[i].pc) begin
            errors++;
            $display("FAIL vec%0d: got req=%b addr=%h vld=%b inst=%h ipc=%h pc=%h want req=%b addr=%h vld=%b inst=%h ipc=%h pc=%h",
                     i, imem_req, imem_addr, inst_valid, inst, inst_pc, pc,
                     vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].inst, vecs[i].ipc, vecs[i].pc);
         end
      end

      // Zero-wait streaming: ack and ready always high, one instruction every 2 cycles.
      jump_en = 1'b0; branch_en = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; imem_ack = 1'b1; inst_ready = 1'b1; use_mem = 1'b1;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!inst_valid && n < 6);
         checks++;
         if (!inst_valid || n != 2 || inst_pc !== 32'(k) || inst !== {16'hA5A5, 16'(k)}) begin
            errors++;
            $display("FAIL stream%0d: got vld=%b gap=%0d ipc=%h inst=%h want vld=1 gap=2 ipc=%h inst=%h",
                     k, inst_valid, n, inst_pc, inst, 32'(k), {16'hA5A5, 16'(k)});
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
